// File: rtl/uart_word_tx_if.sv
// rtl/uart_word_tx_if.sv - word handshake and serial line bundle for uart_word_tx
interface uart_word_tx_if;
    logic        txreq;
    logic [31:0] txdata;
    logic        txready;
    logic        txdone;
    logic        busy;
    logic        tx;

    modport master (
        output txreq,
        output txdata,
        input  txready,
        input  txdone,
        input  busy,
        input  tx
    );

    modport slave (
        input  txreq,
        input  txdata,
        output txready,
        output txdone,
        output busy,
        output tx
    );
endinterface

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - 32-bit word to four 8N1 UART bytes; UART_TX_PARITY_EN adds an even parity bit
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MSB_FIRST    = 0
) (
    input  logic            clk,
    input  logic            reset,
    uart_word_tx_if.slave   bus
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         byte_q, byte_d;
    logic [31:0]        word_q, word_d;
    logic               done_q, done_d;

    logic               div_last;
    logic [1:0]         byte_sel;
    logic [7:0]         cur_byte;

    assign div_last = (div_q == DIV_LAST);

    // Byte counter always counts up; MSB_FIRST only remaps which lane it points at.
    always_comb begin
        byte_sel = (MSB_FIRST != 0) ? ~byte_q : byte_q;
        case (byte_sel)
            2'd0:    cur_byte = word_q[7:0];
            2'd1:    cur_byte = word_q[15:8];
            2'd2:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (bus.txreq) begin
                    word_d  = bus.txdata;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (div_last) begin
                    div_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = S_START;
                    end
                end
            end
            default: begin
                div_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs: an async reset forces IDLE and therefore releases the line at once.
    always_comb begin
        bus.tx      = 1'b1;
        bus.txready = (state_q == S_IDLE);
        bus.busy    = (state_q != S_IDLE);
        bus.txdone  = done_q;
        case (state_q)
            S_START:  bus.tx = 1'b0;
            S_DATA:   bus.tx = cur_byte[bit_q];
`ifdef UART_TX_PARITY_EN
            S_PARITY: bus.tx = ^cur_byte;
`endif
            default:  bus.tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed self-checking bench for uart_word_tx
module tb_uart_word_tx;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FR = 4 * BITS * C;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_word_tx_if if0 ();
    uart_word_tx_if if1 ();

    uart_word_tx #(.CLKS_PER_BIT(C), .MSB_FIRST(0)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
    uart_word_tx #(.CLKS_PER_BIT(C), .MSB_FIRST(1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));

    int   checks = 0;
    int   fails  = 0;
    logic txs [0:1023];
    int   done_cnt;
    int   done_n;

    // Sample n covers the cycle after rising edge accept+n-1; n=1 is the first start-bit cycle.
    task automatic run_word(input int inst, input logic [31:0] data, input int nsamp,
                            input int drop_n, input logic [31:0] data2);
        logic d;
        done_cnt = 0;
        done_n   = 0;
        @(negedge clk);
        if (inst == 0) begin if0.txreq = 1'b1; if0.txdata = data; end
        else           begin if1.txreq = 1'b1; if1.txdata = data; end
        for (int n = 1; n <= nsamp; n++) begin
            @(negedge clk);
            if (inst == 0) begin txs[n] = if0.tx; d = if0.txdone; end
            else           begin txs[n] = if1.tx; d = if1.txdone; end
            if (d === 1'b1) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (n == 1) begin
                if (inst == 0) if0.txdata = data2; else if1.txdata = data2;
            end
            if (n >= drop_n) begin
                if (inst == 0) if0.txreq = 1'b0; else if1.txreq = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] dec(input int off, input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = txs[off + (b * BITS + 1 + i) * C + C / 2];
        return r;
    endfunction

    // First-sent byte lands in bits [7:0].
    function automatic logic [31:0] dec_word(input int off);
        return {dec(off, 3), dec(off, 2), dec(off, 1), dec(off, 0)};
    endfunction

    function automatic logic exp_bit(input logic [31:0] w, input int n);
        int k, b, p;
        logic [7:0] by;
        k = (n - 1) / C;
        b = k / BITS;
        p = k % BITS;
        if (b >= 4) return 1'b1;
        by = w[8*b +: 8];
        if (p == 0) return 1'b0;
        if (p <= 8) return by[p-1];
        if (p == 9 && BITS == 11) return ^by;
        return 1'b1;
    endfunction

    function automatic int wave_errs(input logic [31:0] w, input int off);
        int e = 0;
        for (int n = 1; n <= FR; n++) if (txs[off + n] !== exp_bit(w, n)) e++;
        return e;
    endfunction

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        if0.txreq = 1'b0; if0.txdata = '0;
        if1.txreq = 1'b0; if1.txdata = '0;
        repeat (5) @(negedge clk);
        checks++; if (if0.tx !== 1'b1)      begin fails++; $display("FAIL reset_tx got %b want 1", if0.tx); end
        checks++; if (if0.txready !== 1'b1) begin fails++; $display("FAIL reset_txready got %b want 1", if0.txready); end
        checks++; if (if0.busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b want 0", if0.busy); end
        checks++; if (if0.txdone !== 1'b0)  begin fails++; $display("FAIL reset_txdone got %b want 0", if0.txdone); end
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (if0.tx !== 1'b1 || if1.tx !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL idle_line low_cycles got %0d want 0", bad); end
    endtask

    task automatic test_single();
        logic [BITS-1:0] pat;
        int bad = 0;
`ifdef UART_TX_PARITY_EN
        pat = 11'b10101001010;
`else
        pat = 10'b1101001010;
`endif
        run_word(0, 32'h000000A5, FR + 10, 1, 32'h000000A5);
        for (int p = 0; p < BITS; p++)
            for (int j = 1; j <= C; j++)
                if (txs[p * C + j] !== pat[p]) bad++;
        checks++; if (bad !== 0) begin fails++; $display("FAIL single_byte0_wave bad_samples got %0d want 0", bad); end
        checks++; if (dec_word(0) !== 32'h000000A5) begin fails++; $display("FAIL single_bytes got %h want 000000a5", dec_word(0)); end
        checks++; if (wave_errs(32'h000000A5, 0) !== 0) begin fails++; $display("FAIL single_wave errs got %0d want 0", wave_errs(32'h000000A5, 0)); end
        checks++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done_count got %0d want 1", done_cnt); end
        checks++; if (done_n !== FR + 1) begin fails++; $display("FAIL single_done_time got %0d want %0d", done_n, FR + 1); end
        checks++; if (txs[FR + 1] !== 1'b1) begin fails++; $display("FAIL single_idle_after got %b want 1", txs[FR + 1]); end
`ifdef UART_TX_PARITY_EN
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (txs[(b * BITS + 9) * C + C / 2] !== 1'b0) begin
                fails++; $display("FAIL parity_bit byte%0d got %b want 0", b, txs[(b * BITS + 9) * C + C / 2]);
            end
        end
        checks++; if (done_n !== 177) begin fails++; $display("FAIL parity_word_time got %0d want 177", done_n); end
`endif
    endtask

    task automatic test_byte_order();
        run_word(0, 32'h11223344, FR + 4, 1, 32'h11223344);
        checks++; if (dec_word(0) !== 32'h11223344) begin fails++; $display("FAIL order_lsb_first got %h want 11223344", dec_word(0)); end
        run_word(1, 32'h11223344, FR + 4, 1, 32'h11223344);
        checks++; if (dec_word(0) !== 32'h44332211) begin fails++; $display("FAIL order_msb_first got %h want 44332211", dec_word(0)); end
        checks++; if (done_n !== FR + 1) begin fails++; $display("FAIL order_msb_done got %0d want %0d", done_n, FR + 1); end
    endtask

    task automatic test_back_to_back();
        run_word(0, 32'hCAFE0001, 2 * FR + 10, FR + 2, 32'h5A5A0F0F);
        checks++; if (dec_word(0) !== 32'hCAFE0001) begin fails++; $display("FAIL b2b_first got %h want cafe0001", dec_word(0)); end
        checks++; if (wave_errs(32'hCAFE0001, 0) !== 0) begin fails++; $display("FAIL b2b_first_wave errs got %0d want 0", wave_errs(32'hCAFE0001, 0)); end
        checks++; if (txs[FR + 1] !== 1'b1) begin fails++; $display("FAIL b2b_gap got %b want 1", txs[FR + 1]); end
        checks++; if (txs[FR + 2] !== 1'b0) begin fails++; $display("FAIL b2b_second_start got %b want 0", txs[FR + 2]); end
        checks++; if (dec_word(FR + 1) !== 32'h5A5A0F0F) begin fails++; $display("FAIL b2b_second got %h want 5a5a0f0f", dec_word(FR + 1)); end
        checks++; if (done_cnt !== 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if0.txreq = 1'b1; if0.txdata = 32'h11223344;
        @(negedge clk);
        if0.txreq = 1'b0;
        // Land inside byte 2's data bit 2 (0x22 bit 2 is 0) so the release is visible.
        repeat ((2 * BITS + 3) * C + 1) @(negedge clk);
        checks++; if (if0.tx !== 1'b0) begin fails++; $display("FAIL mid_pre_tx got %b want 0", if0.tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (if0.tx !== 1'b1) begin fails++; $display("FAIL mid_async_tx got %b want 1", if0.tx); end
        checks++; if (if0.busy !== 1'b0) begin fails++; $display("FAIL mid_async_busy got %b want 0", if0.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if0.txready !== 1'b1) begin fails++; $display("FAIL mid_ready_after got %b want 1", if0.txready); end
        run_word(0, 32'hDEADBEEF, FR + 4, 1, 32'hDEADBEEF);
        checks++; if (dec_word(0) !== 32'hDEADBEEF) begin fails++; $display("FAIL mid_new_word got %h want deadbeef", dec_word(0)); end
        checks++; if (wave_errs(32'hDEADBEEF, 0) !== 0) begin fails++; $display("FAIL mid_new_wave errs got %0d want 0", wave_errs(32'hDEADBEEF, 0)); end
        checks++; if (done_n !== FR + 1) begin fails++; $display("FAIL mid_new_done got %0d want %0d", done_n, FR + 1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_byte_order();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
